instr_fetch_sequencer: RTL

//  Sequences the 24-bit instruction memory for the ASIP core: owns the PC,

---
 rtl/instr_fetch_sequencer_pkg.sv | 22 ++
 rtl/instr_fetch_sequencer_if.sv | 32 +++
 rtl/instr_fetch_sequencer_pc_counter.sv | 28 ++
 rtl/instr_fetch_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int N      = 24;
    localparam int ADDR_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0]   HALT_OP = 4'hF;
    localparam logic [ADDR_W-1:0] PC_MAX  = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // True when the opcode field of an instruction word is the HALT opcode.
    function automatic logic is_halt(input logic [N-1:0] instr);
        return instr[N-1 -: OP_W] == HALT_OP;
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Control, instruction-memory and fetch-stage signals of the fetch sequencer.
// The master modport is the sequencer; the slave modport is its environment
// (control, instruction memory and decode).
interface instr_fetch_sequencer_if;
    import fetch_pkg::*;

    logic                 start;
    logic                 script_sel;
    logic                 stall;
    logic                 branch_taken;
    logic [ADDR_W-1:0]    branch_target;
    logic                 imem_sel;
    logic [ADDR_W-1:0]    imem_addr;
    logic [N-1:0]         imem_instr;
    logic [N-1:0]         if_instr;
    logic [ADDR_W-1:0]    if_pc;
    logic                 if_valid;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        input  start, script_sel, stall, branch_taken, branch_target, imem_instr,
        output imem_sel, imem_addr, if_instr, if_pc, if_valid, busy, done, err
    );

    modport slave (
        output start, script_sel, stall, branch_taken, branch_target, imem_instr,
        input  imem_sel, imem_addr, if_instr, if_pc, if_valid, busy, done, err
    );

endinterface

// File: rtl/instr_fetch_sequencer_pc_counter.sv
// Program counter: load has priority over increment; at_max flags the last
// address of the script space so the sequencer can stop instead of wrapping.
module fetch_pc_counter
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              at_max
);

    // PC register: load, increment or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

    assign at_max = (pc == PC_MAX);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory
// select/address and registers each fetched word into a valid-qualified
// fetch stage. A run ends on a HALT opcode or when the PC reaches the top
// of the script space.
module instr_fetch_sequencer
    import fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    instr_fetch_sequencer_if.master bus
);

    fetch_state_t      state;
    fetch_state_t      state_next;

    logic [ADDR_W-1:0] pc;
    logic              pc_at_max;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_value;
    logic              pc_inc;

    logic              issue;
    logic              squash;
    logic              capture_sel;
    logic              clear_err;
    logic              set_err;

    logic              sel_q;
    logic              err_q;
    logic [N-1:0]      if_instr_q;
    logic [ADDR_W-1:0] if_pc_q;
    logic              if_valid_q;

    fetch_pc_counter u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pc_load),
        .load_value (pc_load_value),
        .inc        (pc_inc),
        .pc         (pc),
        .at_max     (pc_at_max)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control; in RUN: branch > stall > HALT > exhaustion > issue.
    always_comb begin
        state_next    = state;
        pc_load       = 1'b0;
        pc_load_value = '0;
        pc_inc        = 1'b0;
        issue         = 1'b0;
        squash        = 1'b0;
        capture_sel   = 1'b0;
        clear_err     = 1'b0;
        set_err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    capture_sel   = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = '0;
                    clear_err     = 1'b1;
                    state_next    = RUN;
                end
            end
            RUN: begin
                if (bus.branch_taken) begin
                    pc_load       = 1'b1;
                    pc_load_value = bus.branch_target;
                    squash        = 1'b1;
                end else if (bus.stall) begin
                    // everything holds
                end else if (is_halt(bus.imem_instr)) begin
                    squash     = 1'b1;
                    state_next = DONE;
                end else if (pc_at_max) begin
                    issue      = 1'b1;
                    set_err    = 1'b1;
                    state_next = DONE;
                end else begin
                    issue  = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            DONE: begin
                squash     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fetch register: capture on issue, drop valid on squash, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else if (issue) begin
            if_instr_q <= bus.imem_instr;
            if_pc_q    <= pc;
            if_valid_q <= 1'b1;
        end else if (squash) begin
            if_valid_q <= 1'b0;
        end
    end

    // Script select is latched only on an accepted start; err is sticky until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (capture_sel) begin
                sel_q <= bus.script_sel;
            end
            if (clear_err) begin
                err_q <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.imem_addr = pc;
    assign bus.imem_sel  = sel_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.err       = err_q;

endmodule
